prefetch_queue: RTL and testbench

//  Parametrised circular byte queue between instruction fetch and prime_decoder.

---
 rtl/prefetch_queue_if.sv | 36 +++
 rtl/prefetch_queue.sv | 84 ++++++++
 tb/tb_prefetch_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/prefetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module : prefetch_queue_if
//  Desc   : Fetch/decode-side signal bundle for the prefetch byte queue.
//  Rev    : 1.0  initial release
// ============================================================================
interface prefetch_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PEEK   = 3
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(PEEK + 1);

    logic                   queue_flush;
    logic                   queue_push;
    logic [DATA_W-1:0]      queue_in;
    logic                   queue_ready;
    logic [PW-1:0]          queue_pop_len;
    logic [PEEK*DATA_W-1:0] queue_out;
    logic [PEEK-1:0]        queue_out_vld;
    logic [CW-1:0]          queue_count;
    logic                   queue_ovf;
    logic                   queue_err;

    modport master (
        output queue_flush, queue_push, queue_in, queue_pop_len,
        input  queue_ready, queue_out, queue_out_vld, queue_count, queue_ovf, queue_err
    );

    modport slave (
        input  queue_flush, queue_push, queue_in, queue_pop_len,
        output queue_ready, queue_out, queue_out_vld, queue_count, queue_ovf, queue_err
    );
endinterface
`default_nettype wire

// File: rtl/prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module : prefetch_queue
//  Desc   : Circular byte queue, 1 push/cycle, PEEK-wide peek, 0..PEEK pops/cycle.
//  Rev    : 1.0  initial release
// ============================================================================
module prefetch_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PEEK   = 3
) (
    input  logic               queue_clk,
    input  logic               queue_reset_n,
    prefetch_queue_if.slave    q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              ovf;
    logic              err;

    logic              full;
    logic              push_ok;
    logic              pop_ok;
    logic [CW-1:0]     pop_ext;

    assign full    = (count == CW'(DEPTH));
    assign pop_ext = CW'(q.queue_pop_len);
    assign push_ok = q.queue_push && !full && !q.queue_flush;
    // Oversized pops (beyond count or PEEK) retire nothing and raise err instead.
    assign pop_ok  = (pop_ext != '0) && (pop_ext <= count) &&
                     (pop_ext <= CW'(PEEK)) && !q.queue_flush;

    always_ff @(posedge queue_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= q.queue_in;
        end
    end

    always_ff @(posedge queue_clk or negedge queue_reset_n) begin
        if (!queue_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else if (q.queue_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + pop_ext[AW-1:0];
            end
            count <= count + CW'(push_ok) - (pop_ok ? pop_ext : '0);
            ovf   <= q.queue_push && full;
            err   <= (pop_ext != '0) && !pop_ok;
        end
    end

    assign q.queue_ready = !full;
    assign q.queue_count = count;
    assign q.queue_ovf   = ovf;
    assign q.queue_err   = err;

    for (genvar i = 0; i < PEEK; i++) begin : g_peek
        logic [AW-1:0] idx;
        logic          vld;
        assign idx = rd_ptr + AW'(i);
        assign vld = (CW'(i) < count);
        assign q.queue_out_vld[i]             = vld;
        assign q.queue_out[i*DATA_W +: DATA_W] = vld ? mem[idx] : '0;
    end
endmodule
`default_nettype wire

// File: tb/tb_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module : tb_prefetch_queue
//  Desc   : Directed vector table plus hand sequences for prefetch_queue.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_prefetch_queue;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    prefetch_queue_if #(.DATA_W(8), .DEPTH(16), .PEEK(3)) qif ();

    prefetch_queue #(.DATA_W(8), .DEPTH(16), .PEEK(3)) dut (
        .queue_clk     (clk),
        .queue_reset_n (rst_n),
        .q             (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        push;
        logic [7:0]  din;
        logic [1:0]  pop;
        logic [4:0]  cnt;
        logic [23:0] out;
        logic [2:0]  vld;
        logic        rdy;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [4:0] cnt, input logic [23:0] out,
                           input logic [2:0] vld, input logic rdy, input logic ovf,
                           input logic err);
        chk({nm, ".count"}, 32'(qif.queue_count), 32'(cnt));
        chk({nm, ".out"},   32'(qif.queue_out),   32'(out));
        chk({nm, ".vld"},   32'(qif.queue_out_vld), 32'(vld));
        chk({nm, ".ready"}, 32'(qif.queue_ready), 32'(rdy));
        chk({nm, ".ovf"},   32'(qif.queue_ovf),   32'(ovf));
        chk({nm, ".err"},   32'(qif.queue_err),   32'(err));
    endtask

    // Drive one cycle of inputs, take the edge, then idle the inputs.
    task automatic cyc(input logic flush, input logic push, input logic [7:0] din,
                       input logic [1:0] pop);
        qif.queue_flush   = flush;
        qif.queue_push    = push;
        qif.queue_in      = din;
        qif.queue_pop_len = pop;
        @(posedge clk);
        #1;
        qif.queue_flush   = 1'b0;
        qif.queue_push    = 1'b0;
        qif.queue_in      = 8'h00;
        qif.queue_pop_len = 2'd0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        qif.queue_flush   = 1'b0;
        qif.queue_push    = 1'b0;
        qif.queue_in      = 8'h00;
        qif.queue_pop_len = 2'd0;

        //           fl push din    pop cnt  out         vld     rdy ovf err
        tbl[0]  = '{1'b0, 1'b1, 8'h20, 2'd0, 5'd1, 24'h000020, 3'b001, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h21, 2'd0, 5'd2, 24'h002120, 3'b011, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 2'd3, 5'd2, 24'h002120, 3'b011, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 2'd0, 5'd2, 24'h002120, 3'b011, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h22, 2'd0, 5'd3, 24'h222120, 3'b111, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h23, 2'd0, 5'd4, 24'h222120, 3'b111, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h24, 2'd0, 5'd5, 24'h222120, 3'b111, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h55, 2'd2, 5'd4, 24'h242322, 3'b111, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 2'd1, 5'd3, 24'h552423, 3'b111, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 2'd0, 5'd3, 24'h552423, 3'b111, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h66, 2'd3, 5'd1, 24'h000066, 3'b001, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 2'd1, 5'd0, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h77, 2'd1, 5'd1, 24'h000077, 3'b001, 1'b1, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 5'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_reset", 5'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b0);

        for (int v = 0; v < 13; v++) begin
            cyc(tbl[v].flush, tbl[v].push, tbl[v].din, tbl[v].pop);
            chk_all($sformatf("vec%0d", v), tbl[v].cnt, tbl[v].out, tbl[v].vld,
                    tbl[v].rdy, tbl[v].ovf, tbl[v].err);
        end

        // Flush at count 7 discards the same-cycle push and pop
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'h70 + 8'(k), 2'd0);
        chk("flush_pre.count", 32'(qif.queue_count), 32'd7);
        cyc(1'b1, 1'b1, 8'h77, 2'd1);
        chk_all("flush", 5'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h88, 2'd0);
        chk_all("flush_push", 5'd1, 24'h000088, 3'b001, 1'b1, 1'b0, 1'b0);

        // Fill to full, then overflow
        cyc(1'b1, 1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, 8'(k), 2'd0);
        chk_all("full", 5'd16, 24'h020100, 3'b111, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'hAA, 2'd0);
        chk_all("ovf", 5'd16, 24'h020100, 3'b111, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'hBB, 2'd1);
        chk_all("ovf_with_pop", 5'd15, 24'h030201, 3'b111, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 2'd0);
        chk("ovf_clears", 32'(qif.queue_ovf), 32'd0);

        // Drain to one entry at the array end, then peek across the wrap
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 8'h00, 2'd3);
        chk_all("drain", 5'd3, 24'h0F0E0D, 3'b111, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 2'd2);
        chk_all("one_left", 5'd1, 24'h00000F, 3'b001, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 8'h10 + 8'(k), 2'd0);
        chk_all("wrap", 5'd6, 24'h11100F, 3'b111, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-fill, no clock edge
        cyc(1'b1, 1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 9; k++) cyc(1'b0, 1'b1, 8'h90 + 8'(k), 2'd0);
        chk("prereset.count", 32'(qif.queue_count), 32'd9);
        #1 rst_n = 1'b0;
        #1;
        chk_all("async_reset", 5'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b1, 8'hC3, 2'd0);
        chk_all("after_reset", 5'd1, 24'h0000C3, 3'b001, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
